// File: rtl/led_pkg.sv
// Shared definitions for the LED switch/PWM driver: mode encoding and
// the per-channel output decode.
package led_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] LED_OFF   = 2'b00;
  localparam logic [MODE_W-1:0] LED_ON    = 2'b01;
  localparam logic [MODE_W-1:0] LED_PWM   = 2'b10;
  localparam logic [MODE_W-1:0] LED_BLINK = 2'b11;

  // Ungated LED level for one channel, given its mode, whether the PWM
  // counter is below its duty, and the current blink phase.
  function automatic logic led_level(input logic [MODE_W-1:0] mode,
                                     input logic              below_duty,
                                     input logic              blink_ph);
    logic level;
    case (mode)
      LED_OFF:   level = 1'b0;
      LED_ON:    level = 1'b1;
      LED_PWM:   level = below_duty;
      LED_BLINK: level = blink_ph & below_duty;
      default:   level = 1'b0;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: prescaler, PWM counter, period pulse and blink phase.
module led_pwm_timebase #(
  parameter int CNT_W     = 8,
  parameter int PRESC     = 50,
  parameter int BLINK_PER = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             period_start,
  output logic             blink_ph
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BW = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;

  logic [PW-1:0]    presc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [BW-1:0]    blink_cnt_r;
  logic             blink_ph_r;
  logic             period_start_r;
  logic             tick_s;
  logic             wrap_s;

  // A tick is the last clock of a prescaler cycle; the period wraps on the
  // tick that moves cnt from all-ones back to zero.
  assign tick_s = (presc_r == PW'(PRESC - 1));
  assign wrap_s = tick_s & (cnt_r == {CNT_W{1'b1}});

  // Prescaler and PWM counter; period_start is high for the first clock of cnt == 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r        <= {PW{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      period_start_r <= 1'b0;
    end else begin
      if (tick_s) begin
        presc_r <= {PW{1'b0}};
        cnt_r   <= cnt_r + CNT_W'(1);
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      period_start_r <= wrap_s;
    end
  end

  // Blink counter counts whole PWM periods and flips the phase when it wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == BW'(BLINK_PER - 1)) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end
  end

  assign cnt          = cnt_r;
  assign tick         = tick_s;
  assign period_start = period_start_r;
  assign blink_ph     = blink_ph_r;

endmodule

// File: rtl/led_switch_pwm.sv
// LED bank driver: each LED is gated by its synchronised slide switch and
// driven OFF / ON / PWM / BLINK from a shared timebase. Duty and mode are
// double-buffered so they only change at PWM period boundaries.
module led_switch_pwm
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = 18,
  parameter int CNT_W     = 8,
  parameter int PRESC     = 50,
  parameter int BLINK_PER = 64,
  parameter int ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] switches,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CNT_W-1:0]    wr_duty,
  input  logic [MODE_W-1:0]   wr_mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                period_start
);

  logic [CNT_W-1:0]    cnt_s;
  logic                tick_unused_s;
  logic                period_start_s;
  logic                blink_ph_s;
  logic [NUM_LEDS-1:0] sw_meta_r;
  logic [NUM_LEDS-1:0] sw_sync_r;
  logic [NUM_LEDS-1:0] led_nxt_s;
  logic [NUM_LEDS-1:0] leds_r;

  led_pwm_timebase #(
    .CNT_W    (CNT_W),
    .PRESC    (PRESC),
    .BLINK_PER(BLINK_PER)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt         (cnt_s),
    .tick        (tick_unused_s),
    .period_start(period_start_s),
    .blink_ph    (blink_ph_s)
  );

  // Two-flop synchroniser for the asynchronous slide switches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_r <= {NUM_LEDS{1'b0}};
      sw_sync_r <= {NUM_LEDS{1'b0}};
    end else begin
      sw_meta_r <= switches;
      sw_sync_r <= sw_meta_r;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic                hit_s;
    logic [CNT_W-1:0]    duty_sh_r;
    logic [CNT_W-1:0]    duty_act_r;
    logic [CNT_W-1:0]    duty_sel_s;
    logic [MODE_W-1:0]   mode_sh_r;
    logic [MODE_W-1:0]   mode_act_r;
    logic [MODE_W-1:0]   mode_sel_s;

    // Addresses at or above NUM_LEDS never match any channel.
    assign hit_s = wr_en & (wr_addr == ADDR_W'(i));

    // Settings in force for the current clock: in the first clock of a
    // period the incoming settings (with write bypass) are used already,
    // so the whole period is driven by one consistent duty and mode.
    always_comb begin
      duty_sel_s = duty_act_r;
      mode_sel_s = mode_act_r;
      if (period_start_s) begin
        if (hit_s) begin
          duty_sel_s = wr_duty;
          mode_sel_s = wr_mode;
        end else begin
          duty_sel_s = duty_sh_r;
          mode_sel_s = mode_sh_r;
        end
      end else begin
        duty_sel_s = duty_act_r;
        mode_sel_s = mode_act_r;
      end
    end

    // Shadow registers take writes; active registers latch at period start.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        duty_sh_r  <= {CNT_W{1'b0}};
        mode_sh_r  <= LED_OFF;
        duty_act_r <= {CNT_W{1'b0}};
        mode_act_r <= LED_OFF;
      end else begin
        if (hit_s) begin
          duty_sh_r <= wr_duty;
          mode_sh_r <= wr_mode;
        end
        if (period_start_s) begin
          duty_act_r <= duty_sel_s;
          mode_act_r <= mode_sel_s;
        end
      end
    end

    assign led_nxt_s[i] = sw_sync_r[i] &
                          led_level(mode_sel_s, (cnt_s < duty_sel_s), blink_ph_s);
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds_r <= {NUM_LEDS{1'b0}};
    end else begin
      leds_r <= led_nxt_s;
    end
  end

  assign leds         = leds_r;
  assign period_start = period_start_s;

endmodule

// File: doc/led_switch_pwm.md
# led_switch_pwm

Parametrised LED bank driver for the DE2-115: each LED is gated by its slide switch and driven in one of four per-channel modes (off, static on, PWM, blinking PWM) from a shared PWM timebase. It is the successor of the combinational switch-to-LED gating stage. Per-channel duty and mode are written through a simple register port from the PWM generator control logic. Duty updates are glitch-free at PWM period boundaries.

## Interface
- `NUM_LEDS`, 18: number of LED/switch channels (1..32).
- `CNT_W`, 8: PWM resolution in bits; period = 2^CNT_W ticks.
- `PRESC`, 50: clocks per PWM tick (>=1).
- `BLINK_PER`, 64: PWM periods per blink half-cycle (>=1).
- `ADDR_W`, 5: write-address width; must satisfy 2^ADDR_W >= NUM_LEDS.

- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `switches` in NUM_LEDS: raw slide switches, asynchronous to `clk`.
- `wr_en` in 1: single-cycle write strobe.
- `wr_addr` in ADDR_W: channel index.
- `wr_duty` in CNT_W: new duty for the channel.
- `wr_mode` in 2: new mode for the channel.
- `leds` out NUM_LEDS: registered LED drive.
- `period_start` out 1: one-cycle pulse on the first tick of each PWM period.

## Operation
- Mode encoding: 00 OFF, 01 ON, 10 PWM, 11 BLINK.
- Timebase:
  - Prescaler counts 0..PRESC-1 and issues `tick` when it wraps.
  - PWM counter `cnt` (CNT_W bits) increments on `tick` and wraps 2^CNT_W-1 -> 0.
  - `period_start` asserts for the clock in which `cnt` wraps to 0.
  - Blink counter counts PWM periods 0..BLINK_PER-1 and toggles `blink_ph` on wrap.
- Per channel:
  - Shadow registers `duty_sh` and `mode_sh` are loaded on `wr_en` when `wr_addr` == channel.
  - Active registers `duty_act` and `mode_act` copy the shadows on `period_start`.
  - If a write coincides with `period_start`, the active registers take the new write data in that same cycle (bypass).
  - `wr_addr` >= NUM_LEDS: the write is ignored and no state changes.
- Switches pass through a 2-FF synchroniser per bit, giving `sw_s`.
- LED equation, registered: `leds[i] <= sw_s[i] & f(mode_act[i])`, where f is:
  - OFF: 0.
  - ON: 1.
  - PWM: (cnt < duty_act).
  - BLINK: blink_ph & (cnt < duty_act).
- PWM boundaries: duty 0 gives always-off; duty 2^CNT_W-1 gives on for all but one tick per period. Full-on is achieved only with mode ON.
- Comparison is unsigned, CNT_W bits, with no extension.

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - `leds`=0 and `period_start`=0.
  - prescaler, `cnt`, blink counter and `blink_ph` = 0.
  - all shadow and active registers = 0, so every channel is OFF.
  - synchroniser flops = 0.
- Reset mid-period discards pending shadow writes; the first `period_start` after reset occurs 2^CNT_W·PRESC clocks after release.
- Switch to LED latency: 3 clocks (2 synchroniser stages + output register).
- Write to LED effect: taken at the next `period_start`; the LED reflects it 1 clock later (output register).
- Mode or duty never changes in mid-period, so there are no partial-period glitches.
- `cnt` to `leds` latency: 1 clock.
- Back-to-back writes to the same channel within one period: the last write wins.

## Structure
- The shared package `led_pkg` holds:
  - mode localparams: `LED_OFF`, `LED_ON`, `LED_PWM`, `LED_BLINK`.
  - the `MODE_W`=2 constant.
- Sub-module `led_pwm_timebase` contains the prescaler, PWM counter, blink counter and `blink_ph`, and outputs `cnt`, `tick`, `period_start`, `blink_ph`.
- The top level holds the synchroniser, the per-channel shadow/active registers in a generate loop, and the output register.

## Test plan
All scenarios use NUM_LEDS=4, CNT_W=4, PRESC=2, BLINK_PER=2.
- **Reset:** hold `rst_n`=0 for 3 clocks with all switches = 1 -> `leds`=0000 and `period_start`=0. After release, the first `period_start` arrives exactly 32 clocks later.
- **Switch gating and latency:** channel 0 in mode ON, toggle `switches[0]` 0->1 -> `leds[0]` rises on the 3rd clock edge after the change. `switches[1]`=1 with channel 1 OFF -> `leds[1]` stays 0.
- **PWM duty:** channel 2 set to PWM with duty 5 -> `leds[2]` high for 10 clocks and low for 22 in every 32-clock period.
  - duty 0 -> never high.
  - duty 15 -> high for 30 of 32 clocks.
- **Glitch-free update:** write duty 12 to channel 2 in mid-period -> the current period still shows 10 high clocks; the next period shows 24. A write coinciding with `period_start` applies in that same period.
- **Blink:** channel 3 in BLINK with duty 8 -> PWM bursts (16 high of 32 clocks) for 2 periods, then 2 periods of all-low, repeating.
- **Illegal address:** write with `wr_addr`=7 -> no channel's `leds` behaviour changes over the following 3 periods.
